// File: rtl/noc_sender_arbiter.sv
// noc_sender_arbiter: round-robin share of one serial NoC sender among N_REQ requesters
module noc_sender_arbiter #(
  parameter int N_REQ          = 4,
  parameter int PACKET_BITS    = 42,
  parameter int PADDING_BITS   = 4,
  parameter int ADDR_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ*PACKET_BITS-1:0]      req_packet,
  input  logic [N_REQ*PADDING_BITS-1:0]     req_padding,
  input  logic [N_REQ*ADDR_BITS-1:0]        req_dst_row,
  input  logic [N_REQ*ADDR_BITS-1:0]        req_dst_col,
  output logic [N_REQ-1:0]                  req_ack,
  output logic [N_REQ-1:0]                  req_err,
  output logic                              snd_enable,
  output logic [PACKET_BITS-1:0]            snd_packet,
  output logic [PADDING_BITS-1:0]           snd_padding,
  output logic [ADDR_BITS-1:0]              snd_dst_row,
  output logic [ADDR_BITS-1:0]              snd_dst_col,
  input  logic                              snd_ack,
  output logic                              busy,
  output logic [$clog2(N_REQ)-1:0]          grant_id
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, sel, idx;
  logic found, timeout;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d, err_q, err_d;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic [PADDING_BITS-1:0] pad_q, pad_d;
  logic [ADDR_BITS-1:0] row_q, row_d, col_q, col_d;
  // first requesting index after the pointer, wrapping around
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    ack_d = '0;
    err_d = '0;
    pkt_d = pkt_q;
    pad_d = pad_q;
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE && found) begin
      state_d = SEND;
      gid_d = sel;
      cnt_d = '0;
      pkt_d = req_packet[sel*PACKET_BITS +: PACKET_BITS];
      pad_d = req_padding[sel*PADDING_BITS +: PADDING_BITS];
      row_d = req_dst_row[sel*ADDR_BITS +: ADDR_BITS];
      col_d = req_dst_col[sel*ADDR_BITS +: ADDR_BITS];
    end else if (state_q == SEND) begin
      cnt_d = cnt_q + 1'b1;
      if (snd_ack || timeout) begin
        state_d = GAP;
        ptr_d = gid_q;
        ack_d[gid_q] = snd_ack;
        err_d[gid_q] = !snd_ack;
      end
    end else if (state_q == GAP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_REQ - 1);
      gid_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      pkt_q <= '0;
      pad_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      pkt_q <= pkt_d;
      pad_q <= pad_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign snd_enable = state_q == SEND;
  assign busy = state_q != IDLE;
  assign grant_id = gid_q;
  assign req_ack = ack_q;
  assign req_err = err_q;
  assign snd_packet = pkt_q;
  assign snd_padding = pad_q;
  assign snd_dst_row = row_q;
  assign snd_dst_col = col_q;
endmodule

// File: tb/tb_noc_sender_arbiter.sv
// tb_noc_sender_arbiter: randomized transactions checked against a round-robin scoreboard
module tb_noc_sender_arbiter;
  localparam int N = 4, PB = 42, DB = 4, AB = 4, TO = 8;
  logic clk = 1'b0, rst = 1'b1, snd_ack = 1'b0;
  logic [N-1:0] req = '0, req_ack, req_err;
  logic [N*PB-1:0] req_packet;
  logic [N*DB-1:0] req_padding;
  logic [N*AB-1:0] req_dst_row, req_dst_col;
  logic snd_enable, busy;
  logic [PB-1:0] snd_packet;
  logic [DB-1:0] snd_padding;
  logic [AB-1:0] snd_dst_row, snd_dst_col;
  logic [1:0] grant_id;
  logic [PB-1:0] pkt [N];
  logic [DB-1:0] pad [N];
  logic [AB-1:0] row [N], col [N];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_packet[g*PB +: PB] = pkt[g];
    assign req_padding[g*DB +: DB] = pad[g];
    assign req_dst_row[g*AB +: AB] = row[g];
    assign req_dst_col[g*AB +: AB] = col[g];
  end
  noc_sender_arbiter #(.N_REQ(N), .PACKET_BITS(PB), .PADDING_BITS(DB), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_packet(req_packet), .req_padding(req_padding),
    .req_dst_row(req_dst_row), .req_dst_col(req_dst_col), .req_ack(req_ack), .req_err(req_err),
    .snd_enable(snd_enable), .snd_packet(snd_packet), .snd_padding(snd_padding),
    .snd_dst_row(snd_dst_row), .snd_dst_col(snd_dst_col), .snd_ack(snd_ack),
    .busy(busy), .grant_id(grant_id)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_data;
    for (int i = 0; i < N; i++) begin
      pkt[i] = PB'({$urandom(), $urandom()});
      pad[i] = DB'($urandom());
      row[i] = AB'($urandom());
      col[i] = AB'($urandom());
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  initial begin
    int ptr, w, d, nsend;
    logic [N-1:0] r, oh;
    logic [PB-1:0] e_pkt;
    logic [3*AB-1:0] e_meta;
    logic drop;
    ptr = N - 1;
    rand_data();
    req = '1;
    repeat (3) begin
      tick();
      chk("rst_ctl", 64'({snd_enable, busy, grant_id, req_ack, req_err}), 64'd0);
      chk("rst_data", 64'({snd_packet, snd_padding, snd_dst_row, snd_dst_col}), 64'd0);
    end
    rst = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (it > 0) rand_data();
      r = N'($urandom_range(1, (1 << N) - 1));
      d = $urandom_range(1, 11);
      drop = 1'($urandom_range(0, 1));
      if (it < 5) begin r = '1; d = 2; drop = 1'b0; end
      if (it == 5) begin r = 4'b0100; pkt[2] = 42'h2A5; row[2] = 4'd4; col[2] = 4'd1; d = 5; end
      if (it == 6) begin r = 4'b0001; d = 20; end
      if (it == 7) begin r = 4'b0001; d = TO; end
      req = r;
      snd_ack = 1'($urandom_range(0, 1));
      w = pick(r, ptr);
      oh = N'(1) << w;
      tick();
      chk("en_rise", 64'(snd_enable), 64'd1);
      chk("grant", 64'(grant_id), 64'(w));
      e_pkt = pkt[w];
      e_meta = {row[w], col[w], pad[w]};
      chk("pkt", 64'(snd_packet), 64'(e_pkt));
      chk("meta", 64'({snd_dst_row, snd_dst_col, snd_padding}), 64'(e_meta));
      rand_data();
      if (drop) req[w] = 1'b0;
      nsend = d <= TO ? d : TO;
      for (int c = 1; c <= nsend; c++) begin
        chk("en_hold", 64'({snd_enable, busy}), 64'd3);
        chk("hold", 64'({snd_packet, snd_dst_row, snd_dst_col, snd_padding}), 64'({e_pkt, e_meta}));
        chk("no_done", 64'({req_ack, req_err}), 64'd0);
        snd_ack = (c == d);
        tick();
      end
      snd_ack = 1'($urandom_range(0, 1));
      chk("gap", 64'({snd_enable, busy}), 64'd1);
      chk("ack", 64'(req_ack), d <= TO ? 64'(oh) : 64'd0);
      chk("err", 64'(req_err), d > TO ? 64'(oh) : 64'd0);
      ptr = w;
      if (it >= 5) req[w] = 1'b0;
      tick();
      chk("idle", 64'({snd_enable, busy, req_ack, req_err}), 64'd0);
    end
    req = 4'b0100;
    snd_ack = 1'b0;
    w = pick(req, ptr);
    tick();
    chk("mid_en", 64'(snd_enable), 64'd1);
    chk("mid_grant", 64'(grant_id), 64'(w));
    rst = 1'b1;
    tick();
    chk("mid_rst", 64'({snd_enable, busy, req_ack, req_err}), 64'd0);
    chk("mid_gid", 64'(grant_id), 64'd0);
    rst = 1'b0;
    req = 4'b0110;
    ptr = N - 1;
    tick();
    chk("post_rst", 64'({snd_enable, req_ack, req_err}), 64'h100);
    chk("post_grant", 64'(grant_id), 64'(pick(4'b0110, ptr)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
